dma_axi_rd_if: RTL

- Read-side AXI master interface. It is the responder to the DMA read streamer's burst-request channel.
- Accepts one burst request at a time (addr/alen/size/valid) and issues it on the AXI AR channel.
- Streams the R beats to the read data path (shift aligner) with backpressure.
- Returns ready/finish to the streamer and reports AXI response and length errors.

---
 rtl/dma_axi_rd_if.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dma_axi_rd_if.sv
// Read-side AXI master for the DMA read streamer.
// Takes one burst request at a time, issues it on AR, forwards R beats to the
// shift aligner with backpressure, pulses finish at burst end and keeps a
// sticky record of the first response/length/ID error.
module dma_axi_rd_if #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stream_req_valid_i,
    input  logic [ADDR_W-1:0] stream_req_addr_i,
    input  logic [7:0]        stream_req_alen_i,
    input  logic [2:0]        stream_req_size_i,
    output logic              stream_resp_ready_o,
    output logic              stream_resp_finish_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    output logic [ID_W-1:0]   m_arid_o,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rlast_i,
    input  logic [ID_W-1:0]   m_rid_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    input  logic              rd_ready_i,
    output logic              err_valid_o,
    output logic [1:0]        err_src_o,
    output logic [ADDR_W-1:0] err_addr_o,
    input  logic              err_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        RD   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_SLVERR = 2'd1;
    localparam logic [1:0] SRC_DECERR = 2'd2;
    localparam logic [1:0] SRC_LENID  = 2'd3;

    state_t     state;
    logic [7:0] beat_cnt;
    logic       in_rd;
    logic       beat;
    logic       cnt_last;
    logic       term;
    logic       len_err;
    logic       id_err;
    logic [1:0] beat_src;
    logic       err_new;

    // The AR fields double as the burst descriptor registers (alen lives in m_arlen_o).
    assign in_rd     = (state == RD);
    assign beat      = in_rd && m_rvalid_i && rd_ready_i;
    assign cnt_last  = (beat_cnt == m_arlen_o);
    // An early rlast ends the burst as well as the internal count reaching alen.
    assign term      = beat && (cnt_last || m_rlast_i);
    assign len_err   = (m_rlast_i != cnt_last);
    assign id_err    = (m_rid_i != ID_W'(AXI_ID));
    assign err_new   = beat && (beat_src != SRC_NONE);

    assign stream_resp_ready_o = (state == IDLE);
    assign m_arburst_o         = 2'b01;
    assign m_arid_o            = ID_W'(AXI_ID);
    assign m_rready_o          = in_rd && rd_ready_i;
    assign rd_valid_o          = in_rd && m_rvalid_i;
    assign rd_data_o           = m_rdata_i;
    assign rd_last_o           = in_rd && cnt_last;

    // Classify the current beat's error, LEN/ID taking priority over DECERR over SLVERR.
    always_comb begin
        beat_src = SRC_NONE;
        if (len_err || id_err) begin
            beat_src = SRC_LENID;
        end else if (m_rresp_i == 2'b11) begin
            beat_src = SRC_DECERR;
        end else if (m_rresp_i == 2'b10) begin
            beat_src = SRC_SLVERR;
        end
    end

    // Burst FSM: accept request, hold AR until handshake, count R beats, pulse finish.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                <= IDLE;
            beat_cnt             <= '0;
            m_arvalid_o          <= 1'b0;
            m_araddr_o           <= '0;
            m_arlen_o            <= '0;
            m_arsize_o           <= '0;
            stream_resp_finish_o <= 1'b0;
        end else begin
            stream_resp_finish_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (stream_req_valid_i) begin
                        m_araddr_o  <= stream_req_addr_i;
                        m_arlen_o   <= stream_req_alen_i;
                        m_arsize_o  <= stream_req_size_i;
                        beat_cnt    <= '0;
                        m_arvalid_o <= 1'b1;
                        state       <= AR;
                    end
                end
                AR: begin
                    if (m_arready_i) begin
                        m_arvalid_o <= 1'b0;
                        state       <= RD;
                    end
                end
                RD: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (term) begin
                        stream_resp_finish_o <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: begin
                    m_arvalid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Sticky error: first error wins until cleared; a clear coinciding with a new error keeps the new one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_valid_o <= 1'b0;
            err_src_o   <= SRC_NONE;
            err_addr_o  <= '0;
        end else if (err_new && (!err_valid_o || err_clr_i)) begin
            err_valid_o <= 1'b1;
            err_src_o   <= beat_src;
            err_addr_o  <= m_araddr_o;
        end else if (err_clr_i) begin
            err_valid_o <= 1'b0;
            err_src_o   <= SRC_NONE;
            err_addr_o  <= '0;
        end
    end

endmodule
